// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes,
// mux selects and the packed control word produced by the decode table.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 4'd0,
      ST_IF    = 4'd1,
      ST_ID    = 4'd2,
      ST_MADDR = 4'd3,
      ST_MRD   = 4'd4,
      ST_MWB   = 4'd5,
      ST_MWR   = 4'd6,
      ST_REXE  = 4'd7,
      ST_RWB   = 4'd8,
      ST_BEQ   = 4'd9,
      ST_JMP   = 4'd10,
      ST_IEXE  = 4'd11,
      ST_IWB   = 4'd12,
      ST_END   = 4'd13
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-signal table. Only the fetch state looks at
// mem_ready (IR/PC load); ID flags unsupported opcodes.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic [OP_W-1:0]    opcode,
   input  logic               mem_ready,
   output ctrl_t              ctrl
);

   always_comb begin
      ctrl = '0;
      case (state_e'(state))
         ST_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         ST_ID: begin
            ctrl.alu_src_b  = SRCB_IMM_S2;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.illegal_op = ~is_legal_op(opcode);
         end
         ST_MADDR, ST_IEXE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         ST_MWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         ST_MWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         ST_REXE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         ST_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         ST_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         ST_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         ST_IWB: begin
            ctrl.reg_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM with memory-ready handshake and run gate.
// Define MC_CTRL_PERF_CNT_EN to add the cycle_cnt / instr_cnt counters.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
`ifdef MC_CTRL_PERF_CNT_EN
#(
   parameter int unsigned CNT_W = 32
)
`endif
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               illegal_op,
   output logic [3:0]         state
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   instr_cnt
`endif
);

   state_e state_q, state_d;
   ctrl_t  ctrl;

   // zero is qualified by the datapath through PCWriteCond
   logic unused_zero;
   assign unused_zero = zero;

   // Next state; run is consulted only at IDLE and at instruction end
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (run) state_d = ST_IF;
         ST_IF:    if (mem_ready) state_d = ST_ID;
         ST_ID: begin
            case (opcode)
               OP_LW, OP_SW: state_d = ST_MADDR;
               OP_RTYPE:     state_d = ST_REXE;
               OP_BEQ:       state_d = ST_BEQ;
               OP_J:         state_d = ST_JMP;
               OP_ADDI:      state_d = ST_IEXE;
               default:      state_d = ST_END;
            endcase
         end
         ST_MADDR: state_d = (opcode == OP_LW) ? ST_MRD : ST_MWR;
         ST_MRD:   if (mem_ready) state_d = ST_MWB;
         ST_REXE:  state_d = ST_RWB;
         ST_IEXE:  state_d = ST_IWB;
         ST_MWR:   if (mem_ready) state_d = run ? ST_IF : ST_IDLE;
         ST_MWB, ST_RWB, ST_BEQ, ST_JMP, ST_IWB, ST_END:
                   state_d = run ? ST_IF : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   mc_ctrl_decode u_decode (
      .state     (state_q),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign IRWrite     = ctrl.ir_write;
   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUOp       = ctrl.alu_op;
   assign PCSource    = ctrl.pc_source;
   assign illegal_op  = ctrl.illegal_op;
   assign state       = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

   // Busy cycles and decoded instructions, both free-running modulo 2^CNT_W
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (state_q != ST_IDLE) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (state_q == ST_ID)   instr_cnt_d = instr_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, run, zero, mem_ready;
   logic [5:0] opcode;
   logic       IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   mc_ctrl_fsm dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .illegal_op(illegal_op),
      .state(state)
`ifdef MC_CTRL_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   logic [16:0] dut_vec;
   assign dut_vec = {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, illegal_op};

   int checks = 0;
   int errors = 0;

   // Reference model: current state plus the remaining steps of the instruction
   state_e      m_st = ST_IDLE;
   state_e      m_rest[$];
   logic [31:0] m_cyc = 0, m_ins = 0;
   logic        m_valid = 1'b0;
   logic        m_ended = 1'b0;

   // Per-instruction observation
   state_e tr[$];
   int irw_cnt, pcw_cnt, pcwc_cnt, rw_cnt, mw_cnt, ill_cnt, irw_first, cyc_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [16:0] exp_ctrl(input state_e st, input logic mr, input logic [5:0] op);
      logic irw, pcw, pcwc, iord, mrd, mwr, m2r, rdst, rw, sa, ill;
      logic [1:0] sb, aop, pcs;
      {irw, pcw, pcwc, iord, mrd, mwr, m2r, rdst, rw, sa, ill} = '0;
      sb = 2'd0; aop = 2'd0; pcs = 2'd0;
      case (st)
         ST_IF:    begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         ST_ID:    begin sb = 2'b11;
                         ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08}); end
         ST_MADDR: begin sa = 1; sb = 2'b10; end
         ST_MRD:   begin mrd = 1; iord = 1; end
         ST_MWB:   begin rw = 1; m2r = 1; end
         ST_MWR:   begin mwr = 1; iord = 1; end
         ST_REXE:  begin sa = 1; aop = 2'b10; end
         ST_RWB:   begin rw = 1; rdst = 1; end
         ST_BEQ:   begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         ST_JMP:   begin pcw = 1; pcs = 2'b10; end
         ST_IEXE:  begin sa = 1; sb = 2'b10; end
         ST_IWB:   begin rw = 1; end
         default:  ;
      endcase
      return {irw, pcw, pcwc, iord, mrd, mwr, m2r, rdst, rw, sa, sb, aop, pcs, ill};
   endfunction

   // One clock: drive, compare on the falling edge, advance the model
   task automatic step(input logic r, input logic rn, input logic [5:0] op,
                       input logic mr, input logic z);
      state_e nx;
      rst = r; run = rn; opcode = op; mem_ready = mr; zero = z;
      @(negedge clk);
      if (m_valid) begin
         chk("state", 32'(state), 32'(m_st));
         chk("ctrl", 32'(dut_vec), 32'(exp_ctrl(m_st, mr, op)));
`ifdef MC_CTRL_PERF_CNT_EN
         chk("cycle_cnt", cycle_cnt, m_cyc);
         chk("instr_cnt", instr_cnt, m_ins);
`endif
      end
      tr.push_back(state_e'(state));
      irw_cnt  += int'(IRWrite);
      pcw_cnt  += int'(PCWrite);
      pcwc_cnt += int'(PCWriteCond);
      rw_cnt   += int'(RegWrite);
      mw_cnt   += int'(MemWrite);
      ill_cnt  += int'(illegal_op);
      if (IRWrite === 1'b1 && irw_first < 0) irw_first = cyc_idx;
      cyc_idx++;

      m_ended = 1'b0;
      nx = m_st;
      if (r) begin
         nx = ST_IDLE;
         m_rest.delete();
      end else if (m_st == ST_IDLE) begin
         nx = rn ? ST_IF : ST_IDLE;
      end else if ((m_st == ST_IF || m_st == ST_MRD || m_st == ST_MWR) && !mr) begin
         nx = m_st;
      end else if (m_st == ST_IF) begin
         nx = ST_ID;
      end else if (m_st == ST_ID) begin
         case (op)
            6'h23:   begin m_rest.push_back(ST_MADDR); m_rest.push_back(ST_MRD); m_rest.push_back(ST_MWB); end
            6'h2B:   begin m_rest.push_back(ST_MADDR); m_rest.push_back(ST_MWR); end
            6'h00:   begin m_rest.push_back(ST_REXE); m_rest.push_back(ST_RWB); end
            6'h08:   begin m_rest.push_back(ST_IEXE); m_rest.push_back(ST_IWB); end
            6'h04:   m_rest.push_back(ST_BEQ);
            6'h02:   m_rest.push_back(ST_JMP);
            default: m_rest.push_back(ST_END);
         endcase
         nx = m_rest.pop_front();
      end else if (m_rest.size() > 0) begin
         nx = m_rest.pop_front();
      end else begin
         nx = rn ? ST_IF : ST_IDLE;
         m_ended = 1'b1;
      end

      if (r) begin
         m_cyc = 0; m_ins = 0;
      end else begin
         if (m_st != ST_IDLE) m_cyc = m_cyc + 1;
         if (m_st == ST_ID)   m_ins = m_ins + 1;
      end
      @(posedge clk);
      m_st = nx;
      if (r) m_valid = 1'b1;
      #1;
   endtask

   // Run one instruction starting in IF, inserting the requested wait cycles
   task automatic do_instr(input logic [5:0] op, input logic z, input int if_w,
                           input int mem_w, input logic run_end, output int len);
      logic mr;
      tr.delete();
      irw_cnt = 0; pcw_cnt = 0; pcwc_cnt = 0; rw_cnt = 0; mw_cnt = 0; ill_cnt = 0;
      irw_first = -1; cyc_idx = 0; len = 0;
      do begin
         mr = 1'b1;
         if (m_st == ST_IF && if_w > 0) begin mr = 1'b0; if_w--; end
         else if ((m_st == ST_MRD || m_st == ST_MWR) && mem_w > 0) begin mr = 1'b0; mem_w--; end
         step(1'b0, run_end, op, mr, z);
         len++;
      end while (!m_ended && len < 40);
      if (!m_ended) chk("instr_timeout", 32'(len), 32'd0);
   endtask

   state_e exp_lw[5] = '{ST_IF, ST_ID, ST_MADDR, ST_MRD, ST_MWB};
   logic [5:0] ops[6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};

   initial begin
      int len;
      logic [5:0] cur_op;
      rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = 6'h00;

      step(1, 0, 6'h00, 1, 0);
      step(1, 0, 6'h00, 1, 0);
      chk("reset_out", 32'(dut_vec), 32'd0);
      step(0, 1, 6'h23, 1, 0);
      chk("idle_sampled", 32'(tr[tr.size()-1]), 32'(ST_IDLE));

      do_instr(6'h23, 0, 0, 0, 1, len);
      chk("lw_len", 32'(len), 32'd5);
      for (int i = 0; i < 5; i++) chk("lw_trace", 32'(tr[i]), 32'(exp_lw[i]));
      chk("lw_irwrite", 32'(irw_cnt), 32'd1);
      chk("lw_regwrite", 32'(rw_cnt), 32'd1);
      chk("lw_next_if", 32'(state), 32'(ST_IF));

      do_instr(6'h2B, 0, 0, 3, 1, len);
      chk("sw_len", 32'(len), 32'd7);
      chk("sw_memwrite", 32'(mw_cnt), 32'd4);
      chk("sw_regwrite", 32'(rw_cnt), 32'd0);

      do_instr(6'h00, 0, 2, 0, 1, len);
      chk("ifwait_len", 32'(len), 32'd6);
      chk("ifwait_irw_first", 32'(irw_first), 32'd2);
      chk("ifwait_irw_cnt", 32'(irw_cnt), 32'd1);
      chk("ifwait_pcw_cnt", 32'(pcw_cnt), 32'd1);
      chk("ifwait_id", 32'(tr[3]), 32'(ST_ID));

      do_instr(6'h04, 1, 0, 0, 1, len);
      chk("beq_len", 32'(len), 32'd3);
      chk("beq_pcwc", 32'(pcwc_cnt), 32'd1);
      do_instr(6'h02, 0, 0, 0, 1, len);
      chk("j_len", 32'(len), 32'd3);
      chk("j_pcw", 32'(pcw_cnt), 32'd2);
      do_instr(6'h08, 0, 0, 0, 1, len);
      chk("addi_len", 32'(len), 32'd4);
      chk("addi_regwrite", 32'(rw_cnt), 32'd1);

      do_instr(6'h3F, 0, 0, 0, 1, len);
      chk("ill_len", 32'(len), 32'd3);
      chk("ill_pulse", 32'(ill_cnt), 32'd1);
      chk("ill_end", 32'(tr[2]), 32'(ST_END));
      chk("ill_no_write", 32'(rw_cnt + mw_cnt), 32'd0);
      chk("ill_next_if", 32'(state), 32'(ST_IF));

      step(0, 1, 6'h00, 1, 0);
      step(0, 1, 6'h00, 1, 0);
      chk("pre_rst_rexe", 32'(state), 32'(ST_REXE));
      step(1, 1, 6'h00, 1, 0);
      chk("rst_mid_state", 32'(state), 32'(ST_IDLE));
      chk("rst_mid_out", 32'(dut_vec), 32'd0);

      step(0, 1, 6'h00, 1, 0);
      do_instr(6'h00, 0, 0, 0, 0, len);
      chk("r_stop_len", 32'(len), 32'd4);
      for (int i = 0; i < 3; i++) step(0, 0, 6'h00, 1, 0);
      chk("stays_idle", 32'(state), 32'(ST_IDLE));

`ifdef MC_CTRL_PERF_CNT_EN
      step(1, 0, 6'h00, 1, 0);
      step(0, 1, 6'h00, 1, 0);
      do_instr(6'h00, 0, 0, 0, 1, len);
      do_instr(6'h00, 0, 0, 0, 0, len);
      chk("perf_instr", instr_cnt, 32'd2);
      chk("perf_cycle", cycle_cnt, 32'd8);
`endif

      cur_op = 6'h00;
      for (int i = 0; i < 3000; i++) begin
         if (m_st == ST_IF || m_st == ST_IDLE) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            cur_op = (sel < 6) ? ops[sel] : 6'($urandom_range(0, 63));
         end
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), cur_op,
              ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
